// File: rtl/cs_sample_feeder.sv
// Sample FIFO feeding the CS block X input one sample per clock, with full-window
// tagging of CS results and a FEED/DRAIN/DONE stream sequencer.
module cs_sample_feeder #(
  parameter int DEPTH = 16,
  parameter int WIN   = 9,
  parameter int LAT   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       overflow,
  input  logic       start,
  output logic [7:0] X,
  output logic       x_valid,
  input  logic [9:0] y_in,
  output logic [9:0] y_out,
  output logic       y_valid,
  output logic [7:0] y_cnt,
  output logic       busy,
  output logic       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(WIN + 1);
  localparam int LW = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_FIN} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [LW-1:0] drain_cnt;
  logic [WW-1:0] wcnt, wcnt_inc;
  logic [LAT-1:0] vld_pipe, full_pipe;
  logic          push, pop, empty, tag, drain_entry;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign push        = wr_en && !full;
  assign pop         = (state == S_FEED) && !empty;
  assign drain_entry = (state == S_FEED) && empty;
  assign wcnt_inc    = (wcnt == WW'(WIN)) ? wcnt : wcnt + WW'(1);
  assign tag         = pop && (wcnt_inc == WW'(WIN));
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start && !empty) state_n = S_FEED;
      S_FEED:  if (empty) state_n = S_DRAIN;
      S_DRAIN: if (drain_cnt == LW'(LAT - 1)) state_n = S_FIN;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + LW'(1) : '0;
    end
  end

  // Storage is not reset; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      X         <= '0;
      x_valid   <= 1'b0;
      wcnt      <= '0;
      vld_pipe  <= '0;
      full_pipe <= '0;
      y_out     <= '0;
      y_valid   <= 1'b0;
      y_cnt     <= '0;
    end else begin
      X       <= pop ? mem[rd_ptr] : '0;
      x_valid <= pop;
      if (drain_entry) wcnt <= '0;
      else if (pop)    wcnt <= wcnt_inc;
      // Stage 0 lines up with x_valid; the last stage lines up with Y at y_in.
      vld_pipe[0]  <= pop;
      full_pipe[0] <= tag;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        full_pipe[i] <= full_pipe[i-1];
      end
      y_valid <= vld_pipe[LAT-1] && full_pipe[LAT-1];
      if (vld_pipe[LAT-1] && full_pipe[LAT-1]) begin
        y_out <= y_in;
        y_cnt <= y_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cs_sample_feeder.sv
// Bench for cs_sample_feeder: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed stream/result counts.
module tb_cs_sample_feeder;
  localparam int DEPTH = 16, WIN = 9, LAT = 2;

  logic       clk = 0, rst = 1, wr_en = 0, start = 0;
  logic [7:0] wr_data = 0;
  logic [9:0] y_in = 10'd5;
  logic       full, overflow, x_valid, y_valid, busy, done;
  logic [7:0] X, y_cnt;
  logic [9:0] y_out;

  cs_sample_feeder #(.DEPTH(DEPTH), .WIN(WIN), .LAT(LAT)) dut (
    .clk(clk), .reset(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .overflow(overflow), .start(start), .X(X), .x_valid(x_valid), .y_in(y_in),
    .y_out(y_out), .y_valid(y_valid), .y_cnt(y_cnt), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(negedge clk) y_in = y_in + 10'd7;

  int n_vec = 0, n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue, the stream a phase with a drain timer,
  // and each full-window pop schedules a capture LAT edges later.
  int q[$], pend[$];
  int m_phase = 0, m_left = 0, m_npop = 0, m_edge = 0, m_pre = 0;
  bit m_pop;
  logic [7:0] e_x = 0, e_ycnt = 0;
  logic [9:0] e_y = 0;
  logic e_xv = 0, e_full = 0, e_ovf = 0, e_yv = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); pend.delete();
      m_phase = 0; m_left = 0; m_npop = 0;
      e_x = 0; e_xv = 0; e_full = 0; e_ovf = 0; e_yv = 0; e_y = 0; e_ycnt = 0;
    end else begin
      m_edge++;
      m_pre = q.size();
      m_pop = (m_phase == 1) && (m_pre > 0);
      e_yv = 0;
      if (pend.size() > 0 && pend[0] == m_edge) begin
        void'(pend.pop_front());
        e_yv = 1; e_y = y_in; e_ycnt = e_ycnt + 8'd1;
      end
      e_xv = m_pop;
      e_x = 0;
      if (m_pop) begin
        e_x = 8'(q.pop_front());
        m_npop++;
        if (m_npop >= WIN) pend.push_back(m_edge + LAT);
      end
      if (wr_en && m_pre < DEPTH) q.push_back(int'(wr_data));
      if (wr_en && m_pre == DEPTH) e_ovf = 1;
      case (m_phase)
        0: if (start && m_pre > 0) m_phase = 1;
        1: if (m_pre == 0) begin m_phase = 2; m_left = LAT; m_npop = 0; end
        2: begin m_left--; if (m_left == 0) m_phase = 3; end
        default: m_phase = 0;
      endcase
      e_full = (q.size() == DEPTH);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("X", X, e_x);
      chk("x_valid", x_valid, e_xv);
      chk("y_out", y_out, e_y);
      chk("y_valid", y_valid, e_yv);
      chk("y_cnt", y_cnt, e_ycnt);
      chk("full", full, e_full);
      chk("overflow", overflow, e_ovf);
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_phase == 3);
    end
  end

  // Stream monitor for the directed checks.
  int cyc = 0, tot_xv = 0, tot_yv = 0, tot_done = 0, xv_runs = 0, yv_runs = 0;
  int last_xv = 0, last_yv = 0;
  logic p_xv = 0, p_yv = 0;
  int xs[$];
  always @(negedge clk) begin
    cyc++;
    if (x_valid === 1'b1) begin
      tot_xv++; xs.push_back(int'(X)); last_xv = cyc;
      if (!p_xv) xv_runs++;
    end
    if (y_valid === 1'b1) begin
      tot_yv++; last_yv = cyc;
      if (!p_yv) yv_runs++;
    end
    if (done === 1'b1) tot_done++;
    p_xv = (x_valid === 1'b1);
    p_yv = (y_valid === 1'b1);
  end

  task automatic push(input logic [7:0] d);
    wr_en = 1; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic go();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  int b_xv, b_yv, b_d, b_xr, b_yr, b_xs;
  task automatic mark();
    b_xv = tot_xv; b_yv = tot_yv; b_d = tot_done; b_xr = xv_runs; b_yr = yv_runs; b_xs = xs.size();
  endtask

  task automatic stream_chk(input string nm, input int nx, input int ny);
    chk({nm, "_xv"}, tot_xv - b_xv, nx);
    chk({nm, "_xruns"}, xv_runs - b_xr, 1);
    chk({nm, "_yv"}, tot_yv - b_yv, ny);
    chk({nm, "_yruns"}, yv_runs - b_yr, (ny > 0) ? 1 : 0);
    chk({nm, "_done"}, tot_done - b_d, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 chk_en = 1;
    chk("rst_busy", busy, 0);
    chk("rst_xv", x_valid, 0);
    chk("rst_ycnt", y_cnt, 0);
    chk("rst_full", full, 0);
    @(negedge clk) rst = 0;

    // Reset mid-stream with 5 entries still queued.
    for (int i = 0; i < 8; i++) push(8'(10 + i));
    go();
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_xv", x_valid, 1);
    #2 rst = 1;
    #1;
    chk("arst_X", X, 0);
    chk("arst_xv", x_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_yv", y_valid, 0);
    chk("arst_yout", y_out, 0);
    chk("arst_full", full, 0);
    chk("arst_ovf", overflow, 0);
    @(negedge clk) rst = 0;
    mark();
    go();
    repeat (3) @(negedge clk);
    chk("empty_start_busy", busy, 0);
    chk("empty_start_xv", tot_xv - b_xv, 0);

    // Exact window 1..9.
    mark();
    for (int i = 1; i <= 9; i++) push(8'(i));
    go();
    wait_idle();
    stream_chk("win9", 9, 1);
    for (int i = 0; i < 9; i++)
      chk("win9_X", (xs.size() > b_xs + i) ? xs[b_xs + i] : -1, i + 1);
    chk("win9_ylat", last_yv - last_xv, LAT);
    chk("win9_ycnt", y_cnt, 1);

    // Longer stream of 12.
    mark();
    for (int i = 0; i < 12; i++) push(8'(40 + 3 * i));
    go();
    wait_idle();
    stream_chk("len12", 12, 4);
    chk("len12_ycnt", y_cnt, 5);

    // Overflow: 17 writes in IDLE.
    mark();
    for (int i = 0; i < 16; i++) push(8'(200 + i));
    chk("ovf_full16", full, 1);
    chk("ovf_ovf16", overflow, 0);
    push(8'd99);
    chk("ovf_ovf17", overflow, 1);
    go();
    wait_idle();
    stream_chk("ovf", 16, 8);
    chk("ovf_ycnt", y_cnt, 13);
    chk("ovf_sticky", overflow, 1);

    // Extension: 9 queued, 5 more written while feeding.
    mark();
    for (int i = 0; i < 9; i++) push(8'(i + 60));
    go();
    for (int i = 0; i < 5; i++) push(8'(i + 120));
    wait_idle();
    stream_chk("ext", 14, 6);
    chk("ext_ycnt", y_cnt, 19);

    // Short stream, then a window that must start counting from zero.
    mark();
    for (int i = 0; i < 5; i++) push(8'(i + 1));
    go();
    wait_idle();
    stream_chk("short", 5, 0);
    chk("short_ycnt", y_cnt, 19);
    mark();
    for (int i = 0; i < 9; i++) push(8'(i + 30));
    go();
    wait_idle();
    stream_chk("after_short", 9, 1);
    chk("after_short_ycnt", y_cnt, 20);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
